mat_vec_mult_fx: RTL and testbench

// Parametrised fixed-point NxN matrix by N-vector multiplier for the 3D vertex path.

---
 rtl/mat_vec_mult_fx.sv | 140 ++++++++++++++
 tb/tb_mat_vec_mult_fx.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_mult_fx.sv
// Fixed-point NxN matrix by N-vector multiplier with valid/ready streaming.
// A loaded matrix is held while vectors are streamed through it. Each vector
// takes N cycles to accumulate, one column per cycle, across N parallel MACs.
// One further cycle rounds and saturates the result into the output register.
module mat_vec_mult_fx #(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     mat_load_in,
  input  logic [N*N*WIDTH-1:0]     mat_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [N*WIDTH-1:0]       vec_in,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [N*WIDTH-1:0]       vec_out,
  output logic [N-1:0]             sat_out,
  output logic                     busy_out
);

  localparam int unsigned KW = $clog2(N);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = PW + $clog2(N);
  localparam int unsigned TW = AW + 1;

  localparam logic signed [TW-1:0] RND  = (FRAC_BITS > 0) ? (TW'(1) << (FRAC_BITS - 1)) : TW'(0);
  localparam logic signed [TW-1:0] MAXV = (TW'(1) << (WIDTH - 1)) - TW'(1);
  localparam logic signed [TW-1:0] MINV = -(TW'(1) << (WIDTH - 1));

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                  state_q;
  logic signed [WIDTH-1:0] mat_q [N][N];
  logic signed [WIDTH-1:0] vec_q [N];
  logic signed [AW-1:0]    acc_q [N];
  logic [KW-1:0]           cnt_q;
  logic                    last_q;

  logic signed [PW-1:0]    prod_c [N];
  logic signed [TW-1:0]    sh_c   [N];
  logic signed [WIDTH-1:0] res_c  [N];
  logic [N-1:0]            sat_c;

  // Vectors are only taken in IDLE, and a matrix load that cycle wins.
  assign ready_out = (state_q == IDLE) && !mat_load_in;
  assign busy_out  = (state_q != IDLE);

  // Products of the current column with the matching vector element.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      prod_c[r] = PW'(mat_q[r][cnt_q]) * PW'(vec_q[cnt_q]);
    end
  end

  // Round half toward +inf, drop fraction bits, clamp to the element range.
  always_comb begin
    sat_c = '0;
    for (int r = 0; r < N; r++) begin
      sh_c[r] = (TW'(acc_q[r]) + RND) >>> FRAC_BITS;
      if (sh_c[r] > MAXV) begin
        res_c[r] = MAXV[WIDTH-1:0];
        sat_c[r] = 1'b1;
      end else if (sh_c[r] < MINV) begin
        res_c[r] = MINV[WIDTH-1:0];
        sat_c[r] = 1'b1;
      end else begin
        res_c[r] = sh_c[r][WIDTH-1:0];
      end
    end
  end

  // Control FSM, matrix/vector capture, accumulation and output register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      valid_out <= 1'b0;
      vec_out   <= '0;
      sat_out   <= '0;
      for (int r = 0; r < N; r++) begin
        vec_q[r] <= '0;
        acc_q[r] <= '0;
        for (int c = 0; c < N; c++) begin
          mat_q[r][c] <= '0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (mat_load_in) begin
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                mat_q[r][c] <= mat_in[(r*N+c)*WIDTH +: WIDTH];
              end
            end
          end else if (valid_in) begin
            for (int r = 0; r < N; r++) begin
              vec_q[r] <= vec_in[r*WIDTH +: WIDTH];
              acc_q[r] <= '0;
            end
            cnt_q   <= '0;
            last_q  <= 1'b0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (!last_q) begin
            for (int r = 0; r < N; r++) begin
              acc_q[r] <= acc_q[r] + AW'(prod_c[r]);
            end
            if (cnt_q == KW'(N - 1)) begin
              last_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + KW'(1);
            end
          end else begin
            for (int r = 0; r < N; r++) begin
              vec_out[r*WIDTH +: WIDTH] <= res_c[r];
            end
            sat_out   <= sat_c;
            valid_out <= 1'b1;
            state_q   <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_vec_mult_fx.sv
// Bench for mat_vec_mult_fx: directed and random vectors, scoreboard checked.
module tb_mat_vec_mult_fx;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned F  = 16;
  localparam int unsigned MW = N * N * W;
  localparam int unsigned VW = N * W;

  typedef struct {
    logic [VW-1:0] vec;
    logic [N-1:0]  sat;
    int            hs;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          mat_load;
  logic [MW-1:0] mat_in;
  logic          valid_in;
  logic          ready_out;
  logic [VW-1:0] vec_in;
  logic          valid_out;
  logic          ready_in;
  logic [VW-1:0] vec_out;
  logic [N-1:0]  sat_out;
  logic          busy_out;

  int            checks;
  int            errors;
  int            cyc;
  exp_t          sb[$];
  logic [MW-1:0] model_mat;
  bit            force_stall;
  bit            rand_bp;
  bit            seen;

  mat_vec_mult_fx #(.N(N), .WIDTH(W), .FRAC_BITS(F)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .mat_load_in (mat_load),
    .mat_in      (mat_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .vec_in      (vec_in),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .vec_out     (vec_out),
    .sat_out     (sat_out),
    .busy_out    (busy_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: exact wide sum, add half LSB, floor shift, clamp.
  function automatic exp_t model(input logic [MW-1:0] m, input logic [VW-1:0] v);
    exp_t e;
    logic signed [127:0] s, hi, lo;
    hi = (128'sd1 <<< (W - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (W - 1));
    e.vec = '0;
    e.sat = '0;
    e.hs  = 0;
    for (int r = 0; r < N; r++) begin
      s = '0;
      for (int c = 0; c < N; c++) begin
        s = s + 128'($signed(m[(r*N+c)*W +: W])) * 128'($signed(v[c*W +: W]));
      end
      if (F > 0) s = s + (128'sd1 <<< (F - 1));
      s = s >>> F;
      if (s > hi) begin
        e.vec[r*W +: W] = hi[W-1:0];
        e.sat[r] = 1'b1;
      end else if (s < lo) begin
        e.vec[r*W +: W] = lo[W-1:0];
        e.sat[r] = 1'b1;
      end else begin
        e.vec[r*W +: W] = s[W-1:0];
      end
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_elem();
    logic [W-1:0] x;
    case ($urandom_range(0, 5))
      0: x = W'($urandom);
      1: x = ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
      default: x = W'($urandom_range(0, 32'h3_FFFF)) - 32'h2_0000;
    endcase
    return x;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int i = 0; i < N * N; i++) m[i*W +: W] = rand_elem();
    return m;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = rand_elem();
    return v;
  endfunction

  // Downstream ready: stalled, random, or always accepting.
  initial begin
    ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (force_stall) ready_in = 1'b0;
      else if (rand_bp) ready_in = ($urandom_range(0, 3) != 0);
      else ready_in = 1'b1;
    end
  end

  // Monitor: compares each presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (valid_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h want no output", vec_out);
      end else begin
        if (!seen) begin
          chk("latency", VW'(cyc - sb[0].hs), VW'(N + 1));
          seen = 1'b1;
        end
        chk("vec_out", vec_out, sb[0].vec);
        chk("sat_out", VW'(sat_out), VW'(sb[0].sat));
        chk("ready_out_in_output", VW'(ready_out), '0);
        chk("busy_in_output", VW'(busy_out), VW'(1));
        if (ready_in) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while ((busy_out || sb.size() != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=%0b pending=%0d want idle", busy_out, sb.size());
    end
  endtask

  // Load a matrix with a competing valid vector that must not be accepted.
  task automatic load_mat(input logic [MW-1:0] m);
    wait_idle();
    @(posedge clk);
    #1;
    mat_load = 1'b1;
    mat_in   = m;
    valid_in = 1'b1;
    vec_in   = rand_vec();
    @(negedge clk);
    chk("ready_out_during_load", VW'(ready_out), '0);
    @(posedge clk);
    #1;
    mat_load  = 1'b0;
    valid_in  = 1'b0;
    model_mat = m;
  endtask

  // Offer a vector; optionally disturb ACCUM with extra valid and matrix loads.
  task automatic send_vec(input logic [VW-1:0] v, input bit disturb);
    int   g = 0;
    bit   done = 1'b0;
    exp_t e;
    @(posedge clk);
    #1;
    vec_in   = v;
    valid_in = 1'b1;
    while (!done && g < 500) begin
      @(negedge clk);
      if (ready_out) begin
        e    = model(model_mat, v);
        e.hs = cyc + 1;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        g++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got ready_out=%0b want 1", ready_out);
    end
    @(posedge clk);
    #1;
    if (disturb && done) begin
      vec_in   = rand_vec();
      mat_load = 1'b1;
      mat_in   = rand_mat();
      repeat (2) begin
        @(posedge clk);
        #1;
      end
      mat_load = 1'b0;
    end
    valid_in = 1'b0;
  endtask

  initial begin
    logic [MW-1:0] m;
    logic [VW-1:0] v;
    int            g;
    checks = 0; errors = 0; cyc = 0;
    force_stall = 1'b0; rand_bp = 1'b0; seen = 1'b0;
    rst = 1'b1; mat_load = 1'b0; mat_in = '0; valid_in = 1'b0; vec_in = '0;
    model_mat = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid_out", VW'(valid_out), '0);
    chk("reset_busy_out", VW'(busy_out), '0);
    chk("reset_vec_out", vec_out, '0);
    chk("reset_sat_out", VW'(sat_out), '0);
    chk("reset_ready_out", VW'(ready_out), VW'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Identity
    m = '0;
    for (int r = 0; r < N; r++) m[(r*N+r)*W +: W] = 32'h0001_0000;
    load_mat(m);
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(k + 1) << 16;
    send_vec(v, 1'b0);

    // Translation
    m = '0;
    for (int r = 0; r < N; r++) m[(r*N+r)*W +: W] = 32'h0001_0000;
    m[(0*N+3)*W +: W] = W'(5 * 65536);
    m[(1*N+3)*W +: W] = W'(-3 * 65536);
    m[(2*N+3)*W +: W] = W'(7 * 65536);
    load_mat(m);
    for (int k = 0; k < N; k++) v[k*W +: W] = 32'h0001_0000;
    send_vec(v, 1'b1);

    // Rounding at the half-LSB point, both signs
    m = '0;
    m[0 +: W] = 32'h0000_8000;
    load_mat(m);
    v = '0;
    v[0 +: W] = 32'h0000_0001;
    send_vec(v, 1'b0);
    v[0 +: W] = 32'hFFFF_FFFF;
    send_vec(v, 1'b0);

    // Saturation, positive and negative
    m = '0;
    for (int r = 0; r < N; r++) m[(r*N+r)*W +: W] = 32'h7FFF_FFFF;
    load_mat(m);
    for (int k = 0; k < N; k++) v[k*W +: W] = 32'h7FFF_FFFF;
    send_vec(v, 1'b0);
    for (int k = 0; k < N; k++) v[k*W +: W] = 32'h8000_0001;
    send_vec(v, 1'b0);

    // Backpressure: hold OUTPUT, then release and expect IDLE
    wait_idle();
    load_mat(rand_mat());
    force_stall = 1'b1;
    send_vec(rand_vec(), 1'b0);
    g = 0;
    while (!valid_out && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("bp_valid_seen", VW'(valid_out), VW'(1));
    repeat (10) begin
      @(negedge clk);
      chk("bp_ready_out", VW'(ready_out), '0);
      chk("bp_valid_held", VW'(valid_out), VW'(1));
    end
    force_stall = 1'b0;
    g = 0;
    while (sb.size() != 0 && g < 50) begin
      @(posedge clk);
      g++;
    end
    @(negedge clk);
    chk("bp_release_busy", VW'(busy_out), '0);
    chk("bp_release_valid", VW'(valid_out), '0);

    // Reset during accumulation clears everything, including the matrix
    load_mat(rand_mat());
    send_vec(rand_vec(), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_valid_out", VW'(valid_out), '0);
    chk("midrst_busy_out", VW'(busy_out), '0);
    chk("midrst_ready_out", VW'(ready_out), VW'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_mat = '0;
    send_vec(rand_vec(), 1'b0);

    // Random stream with random backpressure and ACCUM disturbances
    rand_bp = 1'b1;
    load_mat(rand_mat());
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) load_mat(rand_mat());
      send_vec(rand_vec(), 1'($urandom_range(0, 1)));
    end
    rand_bp = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
